// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NUM_RD combinational read ports,
// writeback bypass, per-register busy scoreboard, busy counter and flush.
// Register 0 reads as zero and is never busy. Indices >= REG_NUM read as zero,
// are never busy, and are ignored on issue and writeback.
module regfile_sb #(
  parameter int REG_NUM        = 32,
  parameter int REG_WIDTH      = 64,
  parameter int REG_ADDR_WIDTH = $clog2(REG_NUM),
  parameter int NUM_RD         = 2,
  parameter int CNT_WIDTH      = $clog2(REG_NUM + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic                             iss_vld,
  input  logic [REG_ADDR_WIDTH-1:0]        iss_rd,
  output logic                             iss_rdy,
  input  logic                             wb_vld,
  input  logic [REG_ADDR_WIDTH-1:0]        wb_addr,
  input  logic [REG_WIDTH-1:0]             wb_data,
  input  logic                             flush,
  output logic [CNT_WIDTH-1:0]             busy_cnt,
  output logic                             wb_err
);

  // The busy vector spans the full index space so any index can address it;
  // bits at or above REG_NUM are never set.
  localparam int SPAN = 2 ** REG_ADDR_WIDTH;

  function automatic logic [SPAN-1:0] valid_mask();
    logic [SPAN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SPAN; i++) begin
      m[i] = (i < unsigned'(REG_NUM));
    end
    return m;
  endfunction

  localparam logic [SPAN-1:0] VALID = valid_mask();

  logic [REG_WIDTH-1:0]      regs [REG_NUM];
  logic [SPAN-1:0]           busy;
  logic [SPAN-1:0]           busy_nxt;
  logic [REG_ADDR_WIDTH-1:0] rd_idx [NUM_RD];
  logic                      wb_hit;
  logic                      iss_set;
  logic                      cnt_inc;
  logic                      cnt_dec;
  logic [CNT_WIDTH-1:0]      cnt_nxt;
  logic                      wb_err_nxt;

  // Split the packed read address bus into per-port indices.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_idx[i] = rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    end
  end

  // Read ports: zero for x0/out-of-range, bypass from writeback, else array.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if ((rd_idx[i] != '0) && VALID[rd_idx[i]]) begin
        if (wb_vld && (wb_addr == rd_idx[i])) begin
          rd_data[i*REG_WIDTH +: REG_WIDTH] = wb_data;
        end else begin
          rd_data[i*REG_WIDTH +: REG_WIDTH] = regs[rd_idx[i]];
          rd_busy[i]                        = busy[rd_idx[i]];
        end
      end
    end
  end

  // Issue handshake, writeback qualification and next scoreboard state.
  always_comb begin
    wb_hit  = wb_vld && (wb_addr != '0) && VALID[wb_addr];
    iss_rdy = (iss_rd == '0) || !busy[iss_rd] || (wb_vld && (wb_addr == iss_rd));
    iss_set = iss_vld && iss_rdy && !flush && (iss_rd != '0) && VALID[iss_rd];

    busy_nxt = busy;
    if (wb_hit) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (iss_set) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end

    // A writeback and reissue to the same busy register leave the count
    // unchanged, so the clear is suppressed when the reissue re-sets it.
    cnt_inc = iss_set && !busy[iss_rd];
    cnt_dec = wb_hit && busy[wb_addr] && !(iss_set && (iss_rd == wb_addr));
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = busy_cnt + {{(CNT_WIDTH-1){1'b0}}, cnt_inc}
                         - {{(CNT_WIDTH-1){1'b0}}, cnt_dec};
    end

    wb_err_nxt = wb_hit && !busy[wb_addr];
  end

  // Register array: writeback data is stored even during a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard state, busy counter and writeback error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      wb_err   <= wb_err_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic for regfile_sb,
// checked against an array/bit-level reference model of the register file.
module tb_regfile_sb;

  localparam int RN = 32;
  localparam int W  = 64;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int CW = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_busy;
  logic           iss_vld;
  logic [AW-1:0]  iss_rd;
  logic           iss_rdy;
  logic           wb_vld;
  logic [AW-1:0]  wb_addr;
  logic [W-1:0]   wb_data;
  logic           flush;
  logic [CW-1:0]  busy_cnt;
  logic           wb_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] m_regs [RN];
  bit           m_busy [RN];
  logic         m_err;
  int           m_cnt;

  regfile_sb #(
    .REG_NUM(RN), .REG_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_RD(NR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_vld(iss_vld), .iss_rd(iss_rd), .iss_rdy(iss_rdy),
    .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .busy_cnt(busy_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_data(int a);
    if (a == 0) return '0;
    if (wb_vld && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(int a);
    if (a == 0) return 1'b0;
    if (wb_vld && int'(wb_addr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_rdy();
    return (iss_rd == 0) || !m_busy[iss_rd] || (wb_vld && wb_addr == iss_rd);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RN; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // Apply the rules of one rising edge to the model using the current inputs.
  task automatic model_edge();
    bit accept;
    accept = iss_vld && exp_rdy() && !flush && (iss_rd != 0);
    m_err  = wb_vld && (wb_addr != 0) && !m_busy[wb_addr];
    if (wb_vld && wb_addr != 0) begin
      m_regs[wb_addr] = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < RN; i++) m_busy[i] = 1'b0;
    end else if (accept) begin
      m_busy[iss_rd] = 1'b1;
    end
    m_cnt = 0;
    for (int i = 1; i < RN; i++) m_cnt += int'(m_busy[i]);
  endtask

  task automatic idle();
    rd_addr = '0; iss_vld = 1'b0; iss_rd = '0;
    wb_vld = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic set_rd(int p, int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int addrs [3];
    addrs = '{0, 5, 31};
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_rd(0, addrs[k]); set_rd(1, addrs[k]);
      #1;
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rd_data[p*W +: W] !== '0 || rd_busy[p] !== 1'b0) begin
          errors++;
          $display("FAIL reset_read port%0d x%0d: got data=%h busy=%b want 0/0",
                   p, addrs[k], rd_data[p*W +: W], rd_busy[p]);
        end
      end
    end
    iss_rd = 5'd5;
    #1;
    checks++;
    if (busy_cnt !== '0) begin errors++; $display("FAIL reset_busy_cnt: got %0d want 0", busy_cnt); end
    checks++;
    if (iss_rdy !== 1'b1) begin errors++; $display("FAIL reset_iss_rdy: got %b want 1", iss_rdy); end
    checks++;
    if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_issue_bypass();
    idle(); iss_vld = 1'b1; iss_rd = 5'd5;
    tick();
    idle(); set_rd(0, 5);
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL issue_busy x5: got %b want 1", rd_busy[0]); end
    checks++;
    if (busy_cnt !== 6'd1) begin errors++; $display("FAIL issue_cnt: got %0d want 1", busy_cnt); end
    wb_vld = 1'b1; wb_addr = 5'd5; wb_data = 64'hDEAD_BEEF;
    #1;
    checks++;
    if (rd_data[0 +: W] !== 64'hDEAD_BEEF || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass x5: got data=%h busy=%b want deadbeef/0", rd_data[0 +: W], rd_busy[0]);
    end
    tick();
    idle(); set_rd(0, 5);
    #1;
    checks++;
    if (busy_cnt !== 6'd0) begin errors++; $display("FAIL wb_cnt: got %0d want 0", busy_cnt); end
    checks++;
    if (rd_data[0 +: W] !== 64'hDEAD_BEEF || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL wb_array x5: got data=%h err=%b want deadbeef/0", rd_data[0 +: W], wb_err);
    end
  endtask

  task automatic test_iss_wb_same();
    idle(); iss_vld = 1'b1; iss_rd = 5'd7;
    tick();
    iss_vld = 1'b1; iss_rd = 5'd7;
    #1;
    checks++;
    if (iss_rdy !== 1'b0) begin errors++; $display("FAIL busy_rdy x7: got %b want 0", iss_rdy); end
    tick();
    idle(); set_rd(0, 7);
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL hold x7: got busy=%b cnt=%0d want 1/1", rd_busy[0], busy_cnt);
    end
    iss_vld = 1'b1; iss_rd = 5'd7;
    wb_vld = 1'b1; wb_addr = 5'd7; wb_data = 64'h1234_5678_9ABC_DEF0;
    #1;
    checks++;
    if (iss_rdy !== 1'b1) begin errors++; $display("FAIL same_rdy x7: got %b want 1", iss_rdy); end
    tick();
    idle(); set_rd(0, 7);
    #1;
    checks++;
    if (rd_data[0 +: W] !== 64'h1234_5678_9ABC_DEF0 || rd_busy[0] !== 1'b1 ||
        busy_cnt !== 6'd1 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL same_x7: got data=%h busy=%b cnt=%0d err=%b want 123456789abcdef0/1/1/0",
               rd_data[0 +: W], rd_busy[0], busy_cnt, wb_err);
    end
  endtask

  task automatic test_flush();
    idle(); flush = 1'b1;
    tick();
    idle();
    for (int r = 1; r <= 10; r++) begin
      iss_vld = 1'b1; iss_rd = AW'(r);
      tick();
    end
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd10) begin errors++; $display("FAIL ten_cnt: got %0d want 10", busy_cnt); end
    flush = 1'b1;
    wb_vld = 1'b1; wb_addr = 5'd3; wb_data = 64'h42;
    iss_vld = 1'b1; iss_rd = 5'd12;
    tick();
    idle(); set_rd(0, 3); set_rd(1, 12);
    #1;
    checks++;
    if (busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt); end
    checks++;
    if (rd_data[0 +: W] !== 64'h42 || rd_busy[0] !== 1'b0 || rd_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_regs: got x3=%h b3=%b b12=%b want 42/0/0",
               rd_data[0 +: W], rd_busy[0], rd_busy[1]);
    end
  endtask

  task automatic test_wb_err();
    idle(); wb_vld = 1'b1; wb_addr = 5'd9; wb_data = 64'h1;
    tick();
    idle(); set_rd(0, 9);
    #1;
    checks++;
    if (wb_err !== 1'b1 || rd_data[0 +: W] !== 64'h1) begin
      errors++;
      $display("FAIL err_pulse x9: got err=%b data=%h want 1/1", wb_err, rd_data[0 +: W]);
    end
    tick();
    checks++;
    if (wb_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", wb_err); end
    wb_vld = 1'b1; wb_addr = 5'd0; wb_data = 64'hFFFF; set_rd(0, 0);
    #1;
    checks++;
    if (rd_data[0 +: W] !== '0) begin errors++; $display("FAIL x0_bypass: got %h want 0", rd_data[0 +: W]); end
    tick();
    idle();
    #1;
    checks++;
    if (wb_err !== 1'b0 || rd_data[0 +: W] !== '0) begin
      errors++;
      $display("FAIL x0_wb: got err=%b data=%h want 0/0", wb_err, rd_data[0 +: W]);
    end
  endtask

  task automatic test_async_reset();
    idle(); iss_vld = 1'b1; iss_rd = 5'd4;
    tick();
    iss_vld = 1'b1; iss_rd = 5'd4;
    wb_vld = 1'b1; wb_addr = 5'd4; wb_data = 64'h55;
    tick();
    idle(); set_rd(0, 4);
    #1;
    checks++;
    if (rd_data[0 +: W] !== 64'h55 || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst x4: got data=%h busy=%b want 55/1", rd_data[0 +: W], rd_busy[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rd_data[0 +: W] !== '0 || rd_busy[0] !== 1'b0 || busy_cnt !== '0) begin
      errors++;
      $display("FAIL async_rst x4: got data=%h busy=%b cnt=%0d want 0/0/0",
               rd_data[0 +: W], rd_busy[0], busy_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NR; p++) begin
        a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
        set_rd(p, a);
      end
      iss_vld = ($urandom_range(0, 1) == 1);
      iss_rd  = AW'($urandom_range(0, 7));
      wb_vld  = ($urandom_range(0, 1) == 1);
      wb_addr = AW'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      flush   = ($urandom_range(0, 19) == 0);
      #1;
      for (int p = 0; p < NR; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        checks++;
        if (rd_data[p*W +: W] !== exp_data(a) || rd_busy[p] !== exp_busy(a)) begin
          errors++;
          $display("FAIL rand_read n=%0d port%0d x%0d: got %h/%b want %h/%b",
                   n, p, a, rd_data[p*W +: W], rd_busy[p], exp_data(a), exp_busy(a));
        end
      end
      checks++;
      if (iss_rdy !== exp_rdy()) begin
        errors++;
        $display("FAIL rand_rdy n=%0d x%0d: got %b want %b", n, iss_rd, iss_rdy, exp_rdy());
      end
      checks++;
      if (int'(busy_cnt) != m_cnt || wb_err !== m_err) begin
        errors++;
        $display("FAIL rand_regd n=%0d: got cnt=%0d err=%b want %0d/%b", n, busy_cnt, wb_err, m_cnt, m_err);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_issue_bypass();
    test_iss_wb_same();
    test_flush();
    test_wb_err();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated scoreboard, the successor to the fixed two-read-port register array. It provides NUM_RD combinational read ports with writeback bypass, tracks pending destination registers with per-register busy bits set at issue and cleared at writeback, and supports a pipeline flush. It sits between decode/issue and the execute/writeback stages of the core.

## Interface

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hardwired to zero.
- REG_WIDTH, 64, register data width in bits.
- REG_ADDR_WIDTH, $clog2(REG_NUM) (5), register index width.
- NUM_RD, 2, number of read ports (1..4).
- CNT_WIDTH, $clog2(REG_NUM+1) (6), width of busy_cnt.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*REG_ADDR_WIDTH  read indices; port i occupies bits [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
- rd_data  out  NUM_RD*REG_WIDTH  read data, packed the same way.
- rd_busy  out  NUM_RD  source register i has a pending write.
- iss_vld  in  1  issue request reserving destination iss_rd.
- iss_rd  in  REG_ADDR_WIDTH  destination index to reserve.
- iss_rdy  out  1  reservation can be accepted this cycle.
- wb_vld  in  1  writeback valid.
- wb_addr  in  REG_ADDR_WIDTH  writeback index.
- wb_data  in  REG_WIDTH  writeback data.
- flush  in  1  clear all busy bits; register contents are kept.
- busy_cnt  out  CNT_WIDTH  number of busy registers (registered).
- wb_err  out  1  registered one-cycle pulse: writeback to a non-busy, nonzero register.

## Operation

- Reset: every register is 0, every busy bit is 0, busy_cnt is 0, wb_err is 0. After reset, all rd_data = 0, rd_busy = 0, and iss_rdy = 1.
- Read port i, index a:
  - a == 0: rd_data = 0, rd_busy = 0.
  - else if wb_vld and wb_addr == a: rd_data = wb_data, rd_busy = 0 (bypass).
  - else: rd_data = reg[a], rd_busy = busy[a].
- iss_rdy = (iss_rd == 0) or !busy[iss_rd] or (wb_vld and wb_addr == iss_rd). It is independent of iss_vld and flush.
- Issue is accepted when iss_vld and iss_rdy and !flush. On acceptance, busy[iss_rd] is set if iss_rd != 0. An issue to x0 is accepted with no effect. iss_vld with iss_rdy = 0 is ignored; the requester holds.
- Writeback with wb_vld and wb_addr != 0:
  - reg[wb_addr] is written with wb_data and busy[wb_addr] is cleared.
  - If busy[wb_addr] was 0, wb_err pulses next cycle and the data is still written.
  - A writeback to x0 is discarded and raises no error.
- Same-register issue and writeback in one cycle: the data is written and busy ends set (the new reservation wins). busy_cnt is unchanged.
- flush: all busy bits clear at the edge and busy_cnt goes to 0. A same-cycle writeback still writes data. A same-cycle issue is dropped.
- busy_cnt always equals the population count of busy[REG_NUM-1:1]. Each edge it is updated by +1 for a newly set bit and −1 for a cleared bit, never over- or underflowing.
- No register holds X after reset; all indices are in range when REG_NUM is a power of two. Indices ≥ REG_NUM read as 0, are never busy, and are ignored on issue and writeback.

## Timing

- Reads: combinational, zero latency, including same-cycle writeback bypass.
- Write and busy update: take effect at the next rising edge. A read in cycle N+1 sees a cycle-N writeback from the array.
- Issue-to-busy: a reservation in cycle N makes rd_busy = 1 for that register from cycle N+1.
- wb_err and busy_cnt: registered, valid one cycle after the causing event.
- rst asserted mid-operation: all state clears immediately (asynchronously). Deassertion is synchronised externally to clk.

## Test plan

- Reset, then read all ports at indices 0, 5, 31 -> rd_data = 0, rd_busy = 0, busy_cnt = 0, iss_rdy = 1.
- Issue x5; next cycle read x5 -> rd_busy = 1, busy_cnt = 1. Writeback x5 = 0xDEAD_BEEF in the same cycle as a read of x5 -> rd_data = 0xDEAD_BEEF, rd_busy = 0; next cycle busy_cnt = 0.
- With x7 busy, present iss_rd = 7 without writeback -> iss_rdy = 0 and no change. With a wb to x7 in the same cycle -> iss_rdy = 1, x7 is written and remains busy, busy_cnt unchanged.
- Issue x1..x10 over ten cycles (busy_cnt = 10), then flush together with wb x3 = 0x42 and iss x12 -> busy_cnt = 0, x3 reads 0x42, x12 is not busy.
- wb x9 = 0x1 with x9 not busy -> wb_err = 1 for exactly one cycle and x9 reads 0x1. wb x0 = 0xFFFF -> x0 reads 0 and wb_err = 0.
- Assert rst asynchronously between edges while x4 holds 0x55 and is busy -> x4 reads 0 and busy_cnt = 0 immediately, before the next edge.
